// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor slice reused LSB-first,
// wrapped in valid/ready request and result handshakes.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff_out,
  output logic             bout_out,
  output logic             zero_out,
  output logic             ovf_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] sh_q, sh_d;     // upper result bits collected so far
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;

  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             bit_d;
  logic             bit_br;
  logic             last_bit;
  logic [WIDTH-1:0] diff_full;

  // One full-subtractor slice on the current LSBs.
  assign bit_d     = a_q[0] ^ b_q[0] ^ br_q;
  assign bit_br    = (~a_q[0] & b_q[0]) | (b_q[0] & br_q) | (~a_q[0] & br_q);
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));
  assign diff_full = {bit_d, sh_q};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          br_d    = bin_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          a_d   = a_q >> 1;
          b_d   = b_q >> 1;
          sh_d  = diff_full[WIDTH-1:1];
          br_d  = bit_br;
          cnt_d = cnt_q + CW'(1);
          if (last_bit) begin
            // a_q[0]/b_q[0]/bit_d are the operand and result MSBs on this cycle.
            diff_d  = diff_full;
            bout_d  = bit_br;
            zero_d  = (diff_full == '0);
            ovf_d   = (a_q[0] != b_q[0]) && (bit_d != a_q[0]);
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset along with the FSM so outputs read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign start_ready = rst_n && (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign diff_out    = diff_q;
  assign bout_out    = bout_q;
  assign zero_out    = zero_q;
  assign ovf_out     = ovf_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized and directed bench for serial_sub_ctrl against an arithmetic model.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         bin_in = 1'b0;
  logic         abort = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] diff_out;
  logic         bout_out;
  logic         zero_out;
  logic         ovf_out;

  int vectors = 0;
  int miscompares = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .a_in(a_in), .b_in(b_in), .bin_in(bin_in), .abort(abort),
    .res_valid(res_valid), .res_ready(res_ready),
    .diff_out(diff_out), .bout_out(bout_out),
    .zero_out(zero_out), .ovf_out(ovf_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer subtraction; packing {diff, bout, zero, ovf}.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    int r;
    logic [W-1:0] d;
    r = int'(a) - int'(b) - int'(bin);
    d = W'(r);
    return {d, r < 0, d == 0, (a[W-1] != b[W-1]) && (d[W-1] != a[W-1])};
  endfunction

  function automatic logic [W+2:0] observed();
    return {diff_out, bout_out, zero_out, ovf_out};
  endfunction

  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int waitc = 0;
    while (!start_ready && waitc < 30) begin
      @(posedge clk); #1;
      waitc++;
    end
    start_valid = 1'b1;
    a_in = a; b_in = b; bin_in = bin;
    @(posedge clk); #1;
    start_valid = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); bin_in = 1'($urandom);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output int lat, output logic [W+2:0] obs);
    accept(a, b, bin);
    wait_result(lat);
    obs = observed();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({start_ready, res_valid, observed()} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want all zero", {start_ready, res_valid, observed()});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({start_ready, res_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_release: ready/valid=%b want 10", {start_ready, res_valid});
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{8'h5A, 8'h00, 8'h80, 8'h10, 8'h00};
    logic [W-1:0] tb [5] = '{8'h3C, 8'h01, 8'h01, 8'h0F, 8'hFF};
    logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    logic [W+2:0] obs, exp;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], tc[i], lat, obs);
      exp = model(ta[i], tb[i], tc[i]);
      vectors++;
      if (lat != W) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, W);
      end
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] a, b;
    logic bin;
    logic [W+2:0] obs, exp;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      if (i % 8 == 0) b = a;
      do_op(a, b, bin, lat, obs);
      exp = model(a, b, bin);
      vectors++;
      if (lat != W || obs !== exp) begin
        miscompares++;
        $display("FAIL random[%0d] a=%h b=%h bin=%b: lat=%0d res=%h want lat=%0d res=%h",
                 i, a, b, bin, lat, obs, W, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W+2:0] exp1, exp2;
    accept(8'h5A, 8'h3C, 1'b0);
    wait_result(lat);
    exp1 = model(8'h5A, 8'h3C, 1'b0);
    exp2 = model(8'h33, 8'h44, 1'b1);
    start_valid = 1'b1;
    a_in = 8'h33; b_in = 8'h44; bin_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({res_valid, start_ready} !== 2'b10 || observed() !== exp1) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: valid/ready=%b res=%h want 10 res=%h",
                 i, {res_valid, start_ready}, observed(), exp1);
      end
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    vectors++;
    if ({res_valid, start_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL backpressure_retire: valid/ready=%b want 01", {res_valid, start_ready});
    end
    @(posedge clk); #1;
    start_valid = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom);
    vectors++;
    if (start_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_accept: start_ready=%b want 0", start_ready);
    end
    wait_result(lat);
    vectors++;
    if (lat != W || observed() !== exp2) begin
      miscompares++;
      $display("FAIL backpressure_second: lat=%0d res=%h want lat=%0d res=%h",
               lat, observed(), W, exp2);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_abort();
    int lat;
    int seen;
    logic [W+2:0] prev, obs, exp;
    do_op(8'h5A, 8'h3C, 1'b0, lat, prev);
    // Abort while processing the third bit.
    accept(8'h77, 8'h11, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    vectors++;
    if ({start_ready, res_valid} !== 2'b10 || observed() !== prev) begin
      miscompares++;
      $display("FAIL abort_mid: ready/valid=%b res=%h want 10 res=%h",
               {start_ready, res_valid}, observed(), prev);
    end
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL abort_no_result: res_valid seen %0d cycles want 0", seen);
    end
    // Abort on the terminal bit beats completion.
    accept(8'h42, 8'h24, 1'b1);
    repeat (W - 1) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    vectors++;
    if ({start_ready, res_valid} !== 2'b10 || observed() !== prev) begin
      miscompares++;
      $display("FAIL abort_terminal: ready/valid=%b res=%h want 10 res=%h",
               {start_ready, res_valid}, observed(), prev);
    end
    // Abort in DONE is ignored.
    accept(8'h9C, 8'h21, 1'b0);
    wait_result(lat);
    exp = model(8'h9C, 8'h21, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    obs = observed();
    vectors++;
    if (res_valid !== 1'b1 || obs !== exp) begin
      miscompares++;
      $display("FAIL abort_in_done: valid=%b res=%h want 1 res=%h", res_valid, obs, exp);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int lat;
    logic [W+2:0] obs, exp;
    accept(8'hC3, 8'h5E, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({start_ready, res_valid, observed()} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_async: got %b want all zero", {start_ready, res_valid, observed()});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({start_ready, res_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL mid_reset_release: ready/valid=%b want 10", {start_ready, res_valid});
    end
    do_op(8'hA5, 8'h5A, 1'b1, lat, obs);
    exp = model(8'hA5, 8'h5A, 1'b1);
    vectors++;
    if (lat != W || obs !== exp) begin
      miscompares++;
      $display("FAIL mid_reset_fresh: lat=%0d res=%h want lat=%0d res=%h", lat, obs, W, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W:0] pend [$];
    logic [2*W:0] op;
    logic [W+2:0] exp;
    int results = 0;
    int last_rdy = -1;
    int cyc = 0;
    start_valid = 1'b1;
    res_ready = 1'b1;
    a_in = W'($urandom); b_in = W'($urandom); bin_in = 1'($urandom);
    while (results < 4 && cyc < 80) begin
      if (res_valid) begin
        op = (pend.size() > 0) ? pend.pop_front() : '0;
        exp = model(op[2*W:W+1], op[W:1], op[0]);
        vectors++;
        if (observed() !== exp) begin
          miscompares++;
          $display("FAIL b2b_result[%0d]: got %h want %h", results, observed(), exp);
        end
        results++;
        if (results == 4) start_valid = 1'b0;
      end
      if (start_ready) begin
        if (last_rdy >= 0) begin
          vectors++;
          if (cyc - last_rdy != W + 2) begin
            miscompares++;
            $display("FAIL b2b_interval: got %0d cycles want %0d", cyc - last_rdy, W + 2);
          end
        end
        last_rdy = cyc;
        pend.push_back({a_in, b_in, bin_in});
      end else begin
        a_in = W'($urandom); b_in = W'($urandom); bin_in = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_valid = 1'b0;
    res_ready = 1'b0;
    vectors++;
    if (results != 4) begin
      miscompares++;
      $display("FAIL b2b_timeout: got %0d results want 4", results);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_abort();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial multi-bit subtractor sequencer. It accepts a WIDTH-bit subtraction request (minuend, subtrahend, borrow-in) over a valid/ready handshake. It runs a single one-bit full-subtractor slice LSB-first, one bit per clock, then presents the difference, borrow-out and status flags over a second valid/ready handshake. It is the controller that time-multiplexes one full-subtractor cell across a whole word, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range is WIDTH >= 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request present.
- start_ready  out  1  block can accept a request.
- a_in  in  WIDTH  minuend.
- b_in  in  WIDTH  subtrahend.
- bin_in  in  1  borrow-in.
- abort  in  1  synchronous cancel of an in-flight operation.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts the result.
- diff_out  out  WIDTH  a_in − b_in − bin_in, modulo 2^WIDTH.
- bout_out  out  1  final borrow-out (unsigned a_in < b_in + bin_in).
- zero_out  out  1  diff_out == 0.
- ovf_out  out  1  two's-complement overflow of the signed subtraction.

## Operation
- FSM states are IDLE, RUN and DONE. Reset places the FSM in IDLE.
- **IDLE:** start_ready=1.
  - If start_valid, latch a_in, b_in and bin_in into shift registers and the borrow flop.
  - Clear the bit counter and go to RUN.
  - Inputs are sampled only on the accept edge; later changes are ignored.
- **RUN:** start_ready=0. Each cycle processes bit i (i = counter, 0..WIDTH−1):
  - d = a[0] ^ b[0] ^ br.
  - br_next = (~a[0] & b[0]) | (b[0] & br) | (~a[0] & br).
  - d shifts into the MSB of the result shift register.
  - The a and b registers shift right by one.
  - The counter increments.
  - On the cycle with counter == WIDTH−1, capture the MSBs of a, b and d for the overflow calculation and go to DONE.
- **Overflow rule:** ovf = (a_msb != b_msb) & (d_msb != a_msb).
- **DONE:** res_valid=1.
  - diff_out, bout_out, zero_out and ovf_out are valid and held stable.
  - When res_ready=1, go to IDLE.
- **abort:** acts only in RUN. It forces IDLE at the next edge, discards partial state and never produces res_valid. In IDLE and DONE, abort is ignored.
- **Result registers:** diff_out, bout_out, zero_out and ovf_out retain the last completed result through IDLE. They update only on entry to DONE.
- **Counter width:** $clog2(WIDTH). The counter never reaches WIDTH; the terminal check is WIDTH−1.

## Timing
- **Reset values:** start_ready=0 while rst_n is low. It becomes 1 in the first cycle after release, when the FSM is in IDLE. All other outputs (res_valid, diff_out, bout_out, zero_out, ovf_out) are 0.
- **Mid-operation reset:** asynchronous reset asserted in RUN or DONE immediately clears all outputs and state; no result is produced.
- **Latency:** accept at edge k, RUN occupies edges k+1..k+WIDTH, and res_valid is high from edge k+WIDTH.
- **Throughput:** start_ready is high only in IDLE, so the minimum repeat interval is WIDTH+2 cycles (1 IDLE, WIDTH RUN, 1 DONE).
- **Backpressure:** while res_valid=1 and res_ready=0, all result outputs hold and start_ready stays 0. start_valid in this window is not accepted.
- **Simultaneous events:**
  - res_ready and start_valid in the same DONE cycle: the result retires and the request is accepted the following IDLE cycle.
  - abort on the terminal RUN cycle: abort wins; the FSM goes to IDLE and there is no res_valid.

## Test plan
All scenarios use WIDTH=8.
- a=0x5A, b=0x3C, bin=0 → diff=0x1E, bout=0, zero=0, ovf=0; res_valid rises exactly 8 cycles after the accept edge.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, zero=0, ovf=0. Then a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1.
- a=0x10, b=0x0F, bin=1 → diff=0x00, zero=1, bout=0, ovf=0. Then a=0x00, b=0xFF, bin=1 → diff=0x00, bout=1, zero=1.
- Hold res_ready=0 for 5 cycles in DONE with start_valid=1 and new operands → outputs stay at the prior result and start_ready=0 throughout. Raising res_ready retires the result, and the new request is accepted on the next edge.
- Assert abort during the 3rd RUN cycle → IDLE at the next edge, start_ready=1, res_valid never asserts, and diff_out keeps the previous result.
- Drop rst_n mid-RUN → res_valid, start_ready and all result outputs go to 0 without waiting for a clock edge. After release, start_ready=1 on the first cycle and a fresh request completes correctly.
